// File: rtl/barrel_rot_sequencer.sv
// Timed 4-bit rotate sequencer: one rotation per prescaler tick,
// finite step count or free-running until stop.
module barrel_rot_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int STEP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_pattern,
  input  logic              cmd_dir,
  input  logic [1:0]        cmd_amt,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              pause,
  input  logic              stop,
  output logic [3:0]        pattern_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [23:0] TMAX = 24'(TICK_DIV - 1);

  state_t            state, state_nx;
  logic [23:0]       presc;
  logic [STEP_W-1:0] rem;
  logic              inf;
  logic              dir;
  logic [1:0]        amt;
  logic              accept;
  logic              tick;

  // Doubled word lets both directions be a plain 4-bit window
  function automatic logic [3:0] rot(
    input logic [3:0] p,
    input logic       d,
    input logic [1:0] k
  );
    logic [7:0] w;
    logic [2:0] sh;
    w = {p, p};
    sh = d ? {1'b0, k} : 3'(3'd4 - {1'b0, k});
    rot = w[sh +: 4];
  endfunction

  assign accept = (state == IDLE) && cmd_valid;
  assign tick   = (state == RUN) && !stop && !pause
               && (presc == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nx = RUN;
      RUN: begin
        if (stop)
          state_nx = IDLE;
        else if (tick && !inf && rem == STEP_W'(1))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_out <= 4'b0000;
      presc       <= '0;
      rem         <= '0;
      inf         <= 1'b0;
      dir         <= 1'b0;
      amt         <= 2'd0;
    end else if (accept) begin
      pattern_out <= cmd_pattern;
      presc       <= '0;
      rem         <= cmd_steps;
      inf         <= (cmd_steps == '0);
      dir         <= cmd_dir;
      amt         <= cmd_amt;
    end else if (tick) begin
      presc       <= '0;
      pattern_out <= rot(pattern_out, dir, amt);
      if (!inf) rem <= rem - STEP_W'(1);
    end else if (state == RUN && !stop && !pause) begin
      presc <= presc + 24'd1;
    end
  end

  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_barrel_rot_sequencer.sv
// Directed bench for barrel_rot_sequencer, TICK_DIV = 4.
// Expected patterns are hand-computed nibble sequences.
module tb_barrel_rot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_pattern = 4'h0;
  logic       cmd_dir = 1'b0;
  logic [1:0] cmd_amt = 2'd0;
  logic [7:0] cmd_steps = 8'd0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] pattern_out;
  logic       busy;
  logic       done;

  int nchk = 0;
  int nerr = 0;
  int ndone = 0;

  barrel_rot_sequencer #(.TICK_DIV(4), .STEP_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern),
    .cmd_dir(cmd_dir),
    .cmd_amt(cmd_amt),
    .cmd_steps(cmd_steps),
    .pause(pause),
    .stop(stop),
    .pattern_out(pattern_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) ndone++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // seq nibble 0 = seed, nibble s = pattern after s steps
  task automatic run_fin(input logic [3:0] p,
                         input logic d,
                         input logic [1:0] a,
                         input int n,
                         input logic [15:0] seq,
                         input logic poke);
    int d0;
    int e;
    d0 = ndone;
    cmd_pattern = p;
    cmd_dir = d;
    cmd_amt = a;
    cmd_steps = 8'(n);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = poke;
    if (poke) begin
      cmd_pattern = ~p;
      cmd_dir = ~d;
      cmd_amt = a + 2'd1;
      cmd_steps = 8'd1;
    end
    chk("accept_busy", busy, 1);
    chk("accept_ready", cmd_ready, 0);
    chk("accept_pat", pattern_out, p);
    for (e = 1; e <= n * 4; e++) begin
      @(posedge clk); #1;
      chk("run_pat", pattern_out, seq[4*(e/4) +: 4]);
      chk("run_done", done, (e == n * 4));
      if (e == n * 4) cmd_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("end_done", done, 0);
    chk("end_ready", cmd_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_pat", pattern_out, seq[4*n +: 4]);
    @(negedge clk);
    chk("done_count", ndone - d0, 1);
  endtask

  initial begin
    #2;
    chk("rst_pat", pattern_out, 4'h0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", cmd_ready, 1);

    // stop and pause in IDLE have no effect
    stop = 1'b1; pause = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; pause = 1'b0;
    chk("idle_stop", cmd_ready, 1);

    // left 1, 3 steps: 0001 -> 0010 -> 0100 -> 1000
    run_fin(4'b0001, 1'b0, 2'd1, 3, 16'h8421, 1'b0);
    // right 2, 2 steps with a competing command held valid
    run_fin(4'b1011, 1'b1, 2'd2, 2, 16'h0BEB, 1'b1);
    // amt 0 still burns steps
    run_fin(4'b0110, 1'b0, 2'd0, 2, 16'h0666, 1'b0);

    // infinite run with pause after first rotation, stop on tick
    begin
      int d0;
      d0 = ndone;
      cmd_pattern = 4'b0001;
      cmd_dir = 1'b0;
      cmd_amt = 2'd1;
      cmd_steps = 8'd0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("inf_e4", pattern_out, 4'b0010);
      pause = 1'b1;
      repeat (3) @(posedge clk);
      #1 pause = 1'b0;
      chk("inf_e7_busy", busy, 1);
      repeat (3) @(posedge clk);
      #1 chk("inf_e10", pattern_out, 4'b0010);
      @(posedge clk);
      #1 chk("inf_e11", pattern_out, 4'b0100);
      repeat (4) @(posedge clk);
      #1 chk("inf_e15", pattern_out, 4'b1000);
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      chk("stop_pat", pattern_out, 4'b1000);
      chk("stop_ready", cmd_ready, 1);
      chk("stop_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 chk("stop_hold", pattern_out, 4'b1000);
      chk("stop_nodone", ndone - d0, 0);
    end

    // async reset mid-run
    cmd_pattern = 4'b0101;
    cmd_dir = 1'b0;
    cmd_amt = 2'd1;
    cmd_steps = 8'd5;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("pre_rst_pat", pattern_out, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pat", pattern_out, 4'h0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_done", done, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    // right 3 equals left 1: 0001 -> 0010
    run_fin(4'b0001, 1'b1, 2'd3, 1, 16'h0021, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
